// File: rtl/sdram_inport_traffic_gen_pkg.sv
// rtl/sdram_inport_traffic_gen_pkg.sv - state type and LFSR step shared by the inport traffic generator
package sdram_inport_traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE, WRITE, WDRAIN, READ, RDRAIN, IWRITE, IREAD, DONE
  } tg_state_e;

  localparam logic [31:0] TG_LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois form: feedback taps are XORed in when the bit shifted out is 1.
  function automatic logic [31:0] tg_lfsr_next(input logic [31:0] value);
    return {1'b0, value[31:1]} ^ (value[0] ? TG_LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sdram_inport_traffic_gen_lfsr.sv
// rtl/sdram_inport_traffic_gen_lfsr.sv - 32-bit Galois LFSR with seed load and single-step enable
module tg_lfsr
  import sdram_inport_traffic_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] value_o
);

  logic [31:0] r_value;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_value <= '0;
    end else if (load_i) begin
      r_value <= SEED;
    end else if (step_i) begin
      r_value <= tg_lfsr_next(r_value);
    end
  end

  assign value_o = r_value;

endmodule

// File: rtl/sdram_inport_traffic_gen.sv
// rtl/sdram_inport_traffic_gen.sv - write/read-back LFSR traffic generator and checker for the sdram inport
module sdram_inport_traffic_gen
  import sdram_inport_traffic_gen_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned ADDR_STRIDE     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] LFSR_SEED       = 32'h0000_0001
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   cfg_base_addr_i,
  input  logic [CNT_W-1:0]    cfg_num_words_i,
  output logic [DATA_W/8-1:0] outport_wr_o,
  output logic                outport_rd_o,
  output logic [ADDR_W-1:0]   outport_addr_o,
  output logic [DATA_W-1:0]   outport_write_data_o,
  input  logic                outport_accept_i,
  input  logic                outport_ack_i,
  input  logic                outport_error_i,
  input  logic [DATA_W-1:0]   outport_read_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic                bus_error_o,
  output logic                proto_error_o
);

  localparam int unsigned       OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]  MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ADDR_STRIDE);

  tg_state_e         r_state, w_next;
  logic [ADDR_W-1:0] r_base, r_addr, r_rd_addr, r_first_addr;
  logic [CNT_W-1:0]  r_num, r_req_cnt, r_err_cnt;
  logic [OUT_W-1:0]  r_out;
  logic              r_issued, r_armed, r_first_done, r_bus_err, r_proto_err, r_pass;
  logic [31:0]       w_w_val, w_r_val;
  logic              w_req_wr, w_req_rd, w_accept, w_start, w_last, w_room;
  logic              w_ack, w_ack_proto, w_rd_ack, w_fail;

  assign w_start     = (r_state == IDLE) && start_i;
  assign w_room      = r_out < MAX_OUT;
  assign w_last      = r_req_cnt == (r_num - CNT_W'(1));
  assign w_accept    = (w_req_wr || w_req_rd) && outport_accept_i;
  assign w_ack       = outport_ack_i && (r_out != '0);
  // r_armed keeps acks that trail a reset from flagging until a run has been started.
  assign w_ack_proto = outport_ack_i && (r_out == '0) && r_armed;
  assign w_rd_ack    = w_ack && (r_state inside {READ, RDRAIN, IREAD});
  assign w_fail      = outport_error_i ||
                       (w_rd_ack && (outport_read_data_i != w_r_val[DATA_W-1:0]));

  tg_lfsr #(.SEED(LFSR_SEED)) u_wr_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (w_start),
    .step_i  (w_accept && w_req_wr),
    .value_o (w_w_val)
  );

  tg_lfsr #(.SEED(LFSR_SEED)) u_rd_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (w_start),
    .step_i  (w_rd_ack),
    .value_o (w_r_val)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_req_wr = 1'b0;
    w_req_rd = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (cfg_num_words_i == '0) w_next = DONE;
          else w_next = mode_i ? IWRITE : WRITE;
        end
      end
      WRITE: begin
        w_req_wr = w_room;
        if (w_accept && w_last) w_next = WDRAIN;
      end
      WDRAIN: if (r_out == '0) w_next = READ;
      READ: begin
        w_req_rd = w_room;
        if (w_accept && w_last) w_next = RDRAIN;
      end
      RDRAIN: if (r_out == '0) w_next = DONE;
      IWRITE: begin
        w_req_wr = !r_issued;
        if (r_issued && (r_out == '0)) w_next = IREAD;
      end
      IREAD: begin
        w_req_rd = !r_issued;
        if (r_issued && (r_out == '0)) w_next = w_last ? DONE : IWRITE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_base       <= '0;
      r_addr       <= '0;
      r_rd_addr    <= '0;
      r_first_addr <= '0;
      r_num        <= '0;
      r_req_cnt    <= '0;
      r_err_cnt    <= '0;
      r_out        <= '0;
      r_issued     <= 1'b0;
      r_armed      <= 1'b0;
      r_first_done <= 1'b0;
      r_bus_err    <= 1'b0;
      r_proto_err  <= 1'b0;
      r_pass       <= 1'b0;
    end else if (w_start) begin
      r_base       <= cfg_base_addr_i;
      r_addr       <= cfg_base_addr_i;
      r_rd_addr    <= cfg_base_addr_i;
      r_num        <= cfg_num_words_i;
      r_req_cnt    <= '0;
      r_out        <= '0;
      r_issued     <= 1'b0;
      r_armed      <= 1'b1;
      r_err_cnt    <= '0;
      r_first_addr <= '0;
      r_first_done <= 1'b0;
      r_bus_err    <= 1'b0;
      r_proto_err  <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (w_accept && !w_ack) r_out <= r_out + OUT_W'(1);
      else if (!w_accept && w_ack) r_out <= r_out - OUT_W'(1);

      // Bulk phases advance per accept; interleaved mode advances once the read of word k is acked.
      if (w_accept) begin
        if (r_state inside {WRITE, READ}) begin
          r_addr    <= w_last ? r_base : r_addr + STRIDE;
          r_req_cnt <= w_last ? '0 : r_req_cnt + CNT_W'(1);
        end else begin
          r_issued <= 1'b1;
        end
      end
      if ((r_state == IWRITE) && (w_next == IREAD)) r_issued <= 1'b0;
      if ((r_state == IREAD) && (w_next == IWRITE)) begin
        r_issued  <= 1'b0;
        r_addr    <= r_addr + STRIDE;
        r_req_cnt <= r_req_cnt + CNT_W'(1);
      end

      if (w_ack_proto) r_proto_err <= 1'b1;
      if (w_ack && outport_error_i) r_bus_err <= 1'b1;
      if (w_ack && w_fail && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (w_rd_ack) begin
        r_rd_addr <= r_rd_addr + STRIDE;
        if (w_fail && !r_first_done) begin
          r_first_addr <= r_rd_addr;
          r_first_done <= 1'b1;
        end
      end

      if (r_state == DONE) r_pass <= (r_err_cnt == '0) && !r_bus_err && !r_proto_err;
    end
  end

  assign outport_wr_o         = {(DATA_W/8){w_req_wr}};
  assign outport_rd_o         = w_req_rd;
  assign outport_addr_o       = (w_req_wr || w_req_rd) ? r_addr : '0;
  assign outport_write_data_o = w_req_wr ? w_w_val[DATA_W-1:0] : '0;
  assign busy_o               = r_state != IDLE;
  assign done_o               = r_state == DONE;
  assign pass_o               = r_pass;
  assign err_cnt_o            = r_err_cnt;
  assign first_err_addr_o     = r_first_addr;
  assign bus_error_o          = r_bus_err;
  assign proto_error_o        = r_proto_err;

endmodule
